ex_stage: RTL and testbench

Execute stage directly downstream of the ID/EX pipeline register. It consumes the decoded fields, computes ALU results and load/store addresses, and registers everything into the EX/MEM boundary. It also owns the HI/LO registers and an iterative multiply/divide unit, which stalls the front of the pipeline while busy. There is no forwarding logic here; operands arrive already resolved.

---
 rtl/ex_stage.sv | 202 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, address generation, HI/LO and iterative mult/div
// Purpose: consumes decoded ID/EX fields, registers results into the EX/MEM boundary,
//          owns HI/LO and a one-bit-per-cycle multiply/divide unit that stalls upstream.
// Ports:   clk, rst_n (async active-low)
//          valid/flush/decoded fields *_id_ex  -> instruction entering EX
//          stall                               -> hold IF/ID/ID-EX while mult/div runs
//          *_ex_mem                            -> registered EX/MEM outputs
module ex_stage #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_id_ex,
    input  logic             flush,
    input  logic [5:0]       opcode_id_ex,
    input  logic [5:0]       func_id_ex,
    input  logic             aluSrc_id_ex,
    input  logic             wr_en_reg_id_ex,
    input  logic [4:0]       wr_num_id_ex,
    input  logic             dm_rw_id_ex,
    input  logic [1:0]       dm_access_sz_id_ex,
    input  logic [WIDTH-1:0] rd0_data_id_ex,
    input  logic [WIDTH-1:0] rd1_data_id_ex,
    input  logic [15:0]      imm_id_ex,
    input  logic [4:0]       shift_amount_id_ex,
    input  logic [WIDTH-1:0] pc_id_ex,
    output logic             stall,
    output logic             valid_ex_mem,
    output logic [WIDTH-1:0] alu_result_ex_mem,
    output logic [WIDTH-1:0] store_data_ex_mem,
    output logic             wr_en_reg_ex_mem,
    output logic [4:0]       wr_num_ex_mem,
    output logic             dm_rw_ex_mem,
    output logic [1:0]       dm_access_sz_ex_mem,
    output logic [WIDTH-1:0] pc_ex_mem
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] opd_q;     // multiplicand (mult) or divisor (div), magnitude
    logic [WIDTH-1:0] acc_hi_q;  // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;  // multiplier bits shifting out / dividend bits -> quotient
    logic             is_div_q, neg_q, neg_rem_q, div0_q;

    logic             is_md, md_signed, md_div, zext_imm;
    logic [WIDTH-1:0] imm_ext, opb, alu_res, a_abs, b_abs;

    // MULT/MULTU/DIV/DIVU occupy func 0x18..0x1B
    assign is_md     = (opcode_id_ex == 6'h00) && (func_id_ex[5:2] == 4'b0110);
    assign md_signed = ~func_id_ex[0];
    assign md_div    = func_id_ex[1];
    assign zext_imm  = opcode_id_ex inside {6'h0C, 6'h0D, 6'h0E};
    assign imm_ext   = zext_imm ? {{(WIDTH-16){1'b0}}, imm_id_ex}
                                : {{(WIDTH-16){imm_id_ex[15]}}, imm_id_ex};
    assign opb       = aluSrc_id_ex ? imm_ext : rd1_data_id_ex;
    assign a_abs     = (md_signed && rd0_data_id_ex[WIDTH-1]) ? -rd0_data_id_ex : rd0_data_id_ex;
    assign b_abs     = (md_signed && rd1_data_id_ex[WIDTH-1]) ? -rd1_data_id_ex : rd1_data_id_ex;

    always_comb begin
        alu_res = '0;
        if (opcode_id_ex == 6'h00) begin
            case (func_id_ex)
                6'h20, 6'h21: alu_res = rd0_data_id_ex + opb;
                6'h22, 6'h23: alu_res = rd0_data_id_ex - opb;
                6'h24:        alu_res = rd0_data_id_ex & opb;
                6'h25:        alu_res = rd0_data_id_ex | opb;
                6'h26:        alu_res = rd0_data_id_ex ^ opb;
                6'h27:        alu_res = ~(rd0_data_id_ex | opb);
                6'h2A:        alu_res = {{(WIDTH-1){1'b0}}, $signed(rd0_data_id_ex) < $signed(opb)};
                6'h2B:        alu_res = {{(WIDTH-1){1'b0}}, rd0_data_id_ex < opb};
                6'h00:        alu_res = rd1_data_id_ex << shift_amount_id_ex;
                6'h02:        alu_res = rd1_data_id_ex >> shift_amount_id_ex;
                6'h03:        alu_res = $signed(rd1_data_id_ex) >>> shift_amount_id_ex;
                6'h10:        alu_res = hi_q;
                6'h12:        alu_res = lo_q;
                default:      alu_res = '0;
            endcase
        end else begin
            case (opcode_id_ex)
                6'h08, 6'h09: alu_res = rd0_data_id_ex + opb;
                6'h0A:        alu_res = {{(WIDTH-1){1'b0}}, $signed(rd0_data_id_ex) < $signed(opb)};
                6'h0B:        alu_res = {{(WIDTH-1){1'b0}}, rd0_data_id_ex < opb};
                6'h0C:        alu_res = rd0_data_id_ex & opb;
                6'h0D:        alu_res = rd0_data_id_ex | opb;
                6'h0E:        alu_res = rd0_data_id_ex ^ opb;
                6'h0F:        alu_res = {imm_id_ex, {(WIDTH-16){1'b0}}};
                default: begin
                    // loads and stores: effective address
                    if (opcode_id_ex >= 6'h20 && opcode_id_ex <= 6'h2B)
                        alu_res = rd0_data_id_ex + opb;
                end
            endcase
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   div_diff, step_hi, step_lo;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_wb, lo_wb;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opd_q};
        div_diff = div_sh[WIDTH-1:0] - opd_q;
        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        // Sign correction on the final step; with a zero divisor the remainder
        // path naturally reproduces the dividend, only LO needs overriding.
        prod  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        hi_wb = is_div_q ? (neg_rem_q ? -step_hi : step_hi) : prod[2*WIDTH-1:WIDTH];
        lo_wb = is_div_q ? (div0_q ? DIV0_LO : (neg_q ? -step_lo : step_lo)) : prod[WIDTH-1:0];
    end

    assign stall = (state_q == BUSY) || (state_q == IDLE && valid_id_ex && is_md);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_id_ex && is_md) begin
                        opd_q     <= md_div ? b_abs : a_abs;
                        acc_lo_q  <= md_div ? a_abs : b_abs;
                        acc_hi_q  <= '0;
                        is_div_q  <= md_div;
                        neg_q     <= md_signed && (rd0_data_id_ex[WIDTH-1] ^ rd1_data_id_ex[WIDTH-1]);
                        neg_rem_q <= md_signed && rd0_data_id_ex[WIDTH-1];
                        div0_q    <= (rd1_data_id_ex == '0);
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        hi_q    <= hi_wb;
                        lo_q    <= lo_wb;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // EX/MEM register: a held mult/div retires only from DONE
    logic v_d;
    assign v_d = valid_id_ex && !flush &&
                 (state_q == DONE || (state_q == IDLE && !is_md));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex_mem        <= 1'b0;
            alu_result_ex_mem   <= '0;
            store_data_ex_mem   <= '0;
            wr_en_reg_ex_mem    <= 1'b0;
            wr_num_ex_mem       <= '0;
            dm_rw_ex_mem        <= 1'b0;
            dm_access_sz_ex_mem <= '0;
            pc_ex_mem           <= '0;
        end else begin
            valid_ex_mem        <= v_d;
            alu_result_ex_mem   <= alu_res;
            store_data_ex_mem   <= rd1_data_id_ex;
            wr_en_reg_ex_mem    <= v_d && wr_en_reg_id_ex && !is_md;
            wr_num_ex_mem       <= wr_num_id_ex;
            dm_rw_ex_mem        <= v_d && dm_rw_id_ex && !is_md;
            dm_access_sz_ex_mem <= dm_access_sz_id_ex;
            pc_ex_mem           <= pc_id_ex;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid_id_ex = 1'b0, flush = 1'b0;
    logic [5:0]  opcode_id_ex = '0, func_id_ex = '0;
    logic        aluSrc_id_ex = 1'b0, wr_en_reg_id_ex = 1'b0, dm_rw_id_ex = 1'b0;
    logic [4:0]  wr_num_id_ex = '0, shift_amount_id_ex = '0;
    logic [1:0]  dm_access_sz_id_ex = '0;
    logic [31:0] rd0_data_id_ex = '0, rd1_data_id_ex = '0, pc_id_ex = '0;
    logic [15:0] imm_id_ex = '0;
    logic        stall, valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem;
    logic [31:0] alu_result_ex_mem, store_data_ex_mem, pc_ex_mem;
    logic [4:0]  wr_num_ex_mem;
    logic [1:0]  dm_access_sz_ex_mem;

    int total = 0, bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0, cur_pc;
    logic [4:0]  cur_wn;
    logic [1:0]  cur_sz;
    logic        cur_st;

    logic [11:0] ops[$] = '{
        {6'h00,6'h20}, {6'h00,6'h21}, {6'h00,6'h22}, {6'h00,6'h23}, {6'h00,6'h24},
        {6'h00,6'h25}, {6'h00,6'h26}, {6'h00,6'h27}, {6'h00,6'h2A}, {6'h00,6'h2B},
        {6'h00,6'h00}, {6'h00,6'h02}, {6'h00,6'h03}, {6'h00,6'h10}, {6'h00,6'h12},
        {6'h00,6'h3F}, {6'h08,6'h00}, {6'h09,6'h00}, {6'h0A,6'h00}, {6'h0B,6'h00},
        {6'h0C,6'h00}, {6'h0D,6'h00}, {6'h0E,6'h00}, {6'h0F,6'h00}, {6'h20,6'h00},
        {6'h23,6'h00}, {6'h28,6'h00}, {6'h2B,6'h00}, {6'h3F,6'h00}};

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_id_ex(valid_id_ex), .flush(flush),
        .opcode_id_ex(opcode_id_ex), .func_id_ex(func_id_ex), .aluSrc_id_ex(aluSrc_id_ex),
        .wr_en_reg_id_ex(wr_en_reg_id_ex), .wr_num_id_ex(wr_num_id_ex),
        .dm_rw_id_ex(dm_rw_id_ex), .dm_access_sz_id_ex(dm_access_sz_id_ex),
        .rd0_data_id_ex(rd0_data_id_ex), .rd1_data_id_ex(rd1_data_id_ex),
        .imm_id_ex(imm_id_ex), .shift_amount_id_ex(shift_amount_id_ex), .pc_id_ex(pc_id_ex),
        .stall(stall), .valid_ex_mem(valid_ex_mem), .alu_result_ex_mem(alu_result_ex_mem),
        .store_data_ex_mem(store_data_ex_mem), .wr_en_reg_ex_mem(wr_en_reg_ex_mem),
        .wr_num_ex_mem(wr_num_ex_mem), .dm_rw_ex_mem(dm_rw_ex_mem),
        .dm_access_sz_ex_mem(dm_access_sz_ex_mem), .pc_ex_mem(pc_ex_mem));

    always #5 clk = ~clk;

    // Reference ALU: what the instruction means, in plain integer arithmetic
    function automatic logic [31:0] alu_model(input logic [5:0] op, fn, input logic [31:0] rs, rt,
                                              input logic [15:0] imm, input logic [4:0] sh,
                                              input logic [31:0] hi, lo);
        logic [31:0] se, ze;
        int si, st, sse;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0000, imm};
        si = rs; st = rt; sse = se;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: return rs + rt;
                6'h22, 6'h23: return rs - rt;
                6'h24: return rs & rt;
                6'h25: return rs | rt;
                6'h26: return rs ^ rt;
                6'h27: return ~(rs | rt);
                6'h2A: return (si < st) ? 32'd1 : 32'd0;
                6'h2B: return (rs < rt) ? 32'd1 : 32'd0;
                6'h00: return rt << sh;
                6'h02: return rt >> sh;
                6'h03: return st >>> sh;
                6'h10: return hi;
                6'h12: return lo;
                default: return 32'd0;
            endcase
        end
        case (op)
            6'h08, 6'h09: return rs + se;
            6'h0A: return (si < sse) ? 32'd1 : 32'd0;
            6'h0B: return (rs < se) ? 32'd1 : 32'd0;
            6'h0C: return rs & ze;
            6'h0D: return rs | ze;
            6'h0E: return rs ^ ze;
            6'h0F: return {imm, 16'h0000};
            default: return (op >= 6'h20 && op <= 6'h2B) ? rs + se : 32'd0;
        endcase
    endfunction

    function automatic void md_model(input logic [5:0] fn, input logic [31:0] rs, rt,
                                     output logic [31:0] hi, lo);
        longint sa, sb;
        logic [63:0] p;
        int si, st;
        si = rs; st = rt;
        if (fn == 6'h19 || fn == 6'h1B) begin
            sa = longint'({32'h0, rs}); sb = longint'({32'h0, rt});
        end else begin
            sa = si; sb = st;
        end
        if (fn == 6'h18 || fn == 6'h19) begin
            p = sa * sb; hi = p[63:32]; lo = p[31:0];
        end else if (rt == 32'h0) begin
            lo = 32'hFFFF_FFFF; hi = rs;
        end else begin
            p = sa / sb; lo = p[31:0];
            p = sa % sb; hi = p[31:0];
        end
    endfunction

    task automatic set_in(input logic [5:0] op, fn, input logic [31:0] rs, rt,
                          input logic [15:0] imm, input logic [4:0] sh, input logic v, we);
        opcode_id_ex = op; func_id_ex = fn; aluSrc_id_ex = (op != 6'h00);
        rd0_data_id_ex = rs; rd1_data_id_ex = rt; imm_id_ex = imm; shift_amount_id_ex = sh;
        valid_id_ex = v; wr_en_reg_id_ex = we;
        cur_wn = 5'($urandom); cur_pc = $urandom; cur_sz = 2'($urandom);
        cur_st = (op >= 6'h28 && op <= 6'h2B);
        wr_num_id_ex = cur_wn; pc_id_ex = cur_pc; dm_access_sz_id_ex = cur_sz; dm_rw_id_ex = cur_st;
    endtask

    task automatic test_reset();
        #3;
        total++; if ({valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem, alu_result_ex_mem, store_data_ex_mem,
                      wr_num_ex_mem, dm_access_sz_ex_mem, pc_ex_mem} !== '0)
            begin bad++; $display("FAIL reset_outputs got res=%0h pc=%0h exp=0", alu_result_ex_mem, pc_ex_mem); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_addi();
        set_in(6'h08, 6'h00, 32'h5, $urandom, 16'hFFFF, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'h4) begin bad++; $display("FAIL addi_result got=%0h exp=4", alu_result_ex_mem); end
        total++; if ({valid_ex_mem, wr_en_reg_ex_mem, wr_num_ex_mem} !== {2'b11, cur_wn})
            begin bad++; $display("FAIL addi_ctrl got v=%0b we=%0b wn=%0d exp 1 1 %0d", valid_ex_mem, wr_en_reg_ex_mem, wr_num_ex_mem, cur_wn); end
    endtask

    task automatic test_slt_sra();
        set_in(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'h1) begin bad++; $display("FAIL slt got=%0h exp=1", alu_result_ex_mem); end
        set_in(6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'h0) begin bad++; $display("FAIL sltu got=%0h exp=0", alu_result_ex_mem); end
        set_in(6'h00, 6'h03, 32'h0, 32'h8000_0000, 16'h0, 5'd4, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%0h exp=f8000000", alu_result_ex_mem); end
    endtask

    // Issue one mult/div, measure the stall, check retirement and read HI/LO back
    task automatic do_md(input logic [5:0] fn, input logic [31:0] rs, rt, ehi, elo, input string nm);
        int n = 0;
        set_in(6'h00, fn, rs, rt, 16'h0, 5'd0, 1'b1, 1'b1);
        #1;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 5) begin
                total++; if (valid_ex_mem !== 1'b0) begin bad++; $display("FAIL %s busy_bubble got=%0b exp=0", nm, valid_ex_mem); end
            end
        end
        total++; if (n != 33) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=33", nm, n); end
        @(posedge clk); #1;
        total++; if ({valid_ex_mem, wr_en_reg_ex_mem} !== 2'b10)
            begin bad++; $display("FAIL %s retire got v=%0b we=%0b exp v=1 we=0", nm, valid_ex_mem, wr_en_reg_ex_mem); end
        set_in(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== elo) begin bad++; $display("FAIL %s lo got=%0h exp=%0h", nm, alu_result_ex_mem, elo); end
        set_in(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== ehi) begin bad++; $display("FAIL %s hi got=%0h exp=%0h", nm, alu_result_ex_mem, ehi); end
        m_hi = ehi; m_lo = elo;
        valid_id_ex = 1'b0;
    endtask

    task automatic test_mult();
        do_md(6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    endtask

    task automatic test_div();
        do_md(6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        do_md(6'h1B, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, "divu0");
    endtask

    task automatic test_random_alu();
        for (int i = 0; i < 150; i++) begin
            logic [5:0] op, fn;
            logic [31:0] rs, rt, exp;
            logic [15:0] imm;
            logic [4:0] sh;
            logic v, we, fl, ok;
            int k;
            k = $urandom_range(0, ops.size() - 1);
            op = ops[k][11:6]; fn = ops[k][5:0];
            rs = $urandom; rt = $urandom;
            if ($urandom_range(0, 3) == 0) rt = $urandom_range(0, 3);
            imm = 16'($urandom); sh = 5'($urandom);
            v = ($urandom_range(0, 4) != 0); we = 1'($urandom); fl = ($urandom_range(0, 9) == 0);
            exp = alu_model(op, fn, rs, rt, imm, sh, m_hi, m_lo);
            set_in(op, fn, rs, rt, imm, sh, v, we);
            flush = fl;
            @(posedge clk); #1;
            ok = v & ~fl;
            total++; if (valid_ex_mem !== ok) begin bad++; $display("FAIL rnd_valid op=%0h got=%0b exp=%0b", op, valid_ex_mem, ok); end
            total++; if (wr_en_reg_ex_mem !== (ok & we)) begin bad++; $display("FAIL rnd_wren got=%0b exp=%0b", wr_en_reg_ex_mem, ok & we); end
            total++; if (dm_rw_ex_mem !== (ok & cur_st)) begin bad++; $display("FAIL rnd_dmrw got=%0b exp=%0b", dm_rw_ex_mem, ok & cur_st); end
            if (ok) begin
                total++; if (alu_result_ex_mem !== exp)
                    begin bad++; $display("FAIL rnd_result op=%0h fn=%0h rs=%0h rt=%0h imm=%0h got=%0h exp=%0h", op, fn, rs, rt, imm, alu_result_ex_mem, exp); end
                total++; if ({wr_num_ex_mem, pc_ex_mem, dm_access_sz_ex_mem} !== {cur_wn, cur_pc, cur_sz})
                    begin bad++; $display("FAIL rnd_fields got pc=%0h wn=%0d exp pc=%0h wn=%0d", pc_ex_mem, wr_num_ex_mem, cur_pc, cur_wn); end
                if (cur_st) begin
                    total++; if (store_data_ex_mem !== rt) begin bad++; $display("FAIL rnd_store got=%0h exp=%0h", store_data_ex_mem, rt); end
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_random_md();
        for (int i = 0; i < 6; i++) begin
            logic [5:0] fn;
            logic [31:0] rs, rt, ehi, elo;
            fn = 6'h18 + 6'($urandom_range(0, 3));
            rs = $urandom; rt = $urandom;
            if (i == 4) rt = $urandom_range(1, 9);
            if (i == 5) rs = $urandom_range(0, 1000);
            md_model(fn, rs, rt, ehi, elo);
            do_md(fn, rs, rt, ehi, elo, "rnd_md");
        end
    endtask

    task automatic test_flush();
        // flush in the issue cycle keeps the unit idle
        set_in(6'h00, 6'h18, $urandom, $urandom, 16'h0, 5'd0, 1'b1, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_id_ex = 1'b0; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_issue_stall got=%0b exp=0", stall); end
        // flush mid-iteration at counter 10
        set_in(6'h00, 6'h19, $urandom, $urandom, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%0b exp=1", stall); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_id_ex = 1'b0; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
        total++; if (valid_ex_mem !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", valid_ex_mem); end
        set_in(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== m_hi) begin bad++; $display("FAIL flush_hi got=%0h exp=%0h", alu_result_ex_mem, m_hi); end
        set_in(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== m_lo) begin bad++; $display("FAIL flush_lo got=%0h exp=%0h", alu_result_ex_mem, m_lo); end
    endtask

    task automatic test_async_reset();
        set_in(6'h00, 6'h1A, $urandom, 32'd3, 16'h0, 5'd0, 1'b1, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        valid_id_ex = 1'b0;
        #1;
        total++; if ({valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem, alu_result_ex_mem, store_data_ex_mem,
                      wr_num_ex_mem, dm_access_sz_ex_mem, pc_ex_mem} !== '0)
            begin bad++; $display("FAIL arst_outputs got pc=%0h wn=%0d exp=0", pc_ex_mem, wr_num_ex_mem); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_stall got=%0b exp=0", stall); end
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_idle got stall=%0b exp=0", stall); end
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'h0) begin bad++; $display("FAIL arst_hi got=%0h exp=0", alu_result_ex_mem); end
        set_in(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        total++; if (alu_result_ex_mem !== 32'h0) begin bad++; $display("FAIL arst_lo got=%0h exp=0", alu_result_ex_mem); end
        valid_id_ex = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slt_sra();
        test_mult();
        test_div();
        test_random_alu();
        test_random_md();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
